// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - RV32I opcode constants and decoded instruction record
package decode_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;

   typedef struct packed {
      logic [6:0]  op_type;
      logic [2:0]  op_sub;
      logic [6:0]  op_flag;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        rs1_used;
      logic        rs2_used;
      logic        rd_used;
      logic        illegal;
   } decoded_t;

endpackage

// File: rtl/rv32_decode_comb.sv
// rtl/rv32_decode_comb.sv - combinational RV32I field and immediate decoder
module rv32_decode_comb
   import decode_pkg::*;
(
   input  logic [31:0] instr,
   output decoded_t    dec
);

   always_comb begin
      dec         = '0;
      dec.op_type = instr[6:0];
      dec.op_sub  = instr[14:12];
      case (instr[6:0])
         OPC_LUI, OPC_AUIPC: begin
            dec.imm     = {instr[31:12], 12'b0};
            dec.rd_used = 1'b1;
         end
         OPC_JAL: begin
            dec.imm     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            dec.rd_used = 1'b1;
         end
         OPC_JALR, OPC_LOAD: begin
            dec.imm      = {{20{instr[31]}}, instr[31:20]};
            dec.rs1_used = 1'b1;
            dec.rd_used  = 1'b1;
         end
         OPC_BRANCH: begin
            dec.imm      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            dec.rs1_used = 1'b1;
            dec.rs2_used = 1'b1;
         end
         OPC_STORE: begin
            dec.imm      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            dec.rs1_used = 1'b1;
            dec.rs2_used = 1'b1;
         end
         OPC_OPIMM: begin
            dec.rs1_used = 1'b1;
            dec.rd_used  = 1'b1;
            // shift-immediates carry a shamt and the funct7 qualifier instead of a 12-bit imm
            if (instr[13:12] == 2'b01) begin
               dec.imm     = {27'b0, instr[24:20]};
               dec.op_flag = instr[31:25];
            end else begin
               dec.imm = {{20{instr[31]}}, instr[31:20]};
            end
         end
         OPC_OP: begin
            dec.rs1_used = 1'b1;
            dec.rs2_used = 1'b1;
            dec.rd_used  = 1'b1;
            dec.op_flag  = instr[31:25];
         end
         OPC_FENCE: begin
            dec.imm = {24'b0, instr[27:20]};
         end
         default: begin
            dec.illegal = 1'b1;
         end
      endcase
      if (instr[11:7] == 5'd0) begin
         dec.rd_used = 1'b0;
      end
      dec.rs1 = dec.rs1_used ? instr[19:15] : 5'd0;
      dec.rs2 = dec.rs2_used ? instr[24:20] : 5'd0;
      dec.rd  = dec.rd_used  ? instr[11:7]  : 5'd0;
   end

endmodule

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - fetch-to-issue instruction FIFO with registered decode slot (option: DECODE_BYPASS_EN)
module decode_queue
   import decode_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_instr,
   input  logic [XLEN-1:0]          in_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [6:0]               out_op_type,
   output logic [2:0]               out_op_sub,
   output logic [6:0]               out_op_flag,
   output logic [XLEN-1:0]          out_imm,
   output logic [4:0]               out_rs1,
   output logic [4:0]               out_rs2,
   output logic [4:0]               out_rd,
   output logic                     out_rs1_used,
   output logic                     out_rs2_used,
   output logic                     out_rd_used,
   output logic                     out_illegal,
   output logic [XLEN-1:0]          out_pc,
   output logic [31:0]              out_instr,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]     mem_instr [DEPTH];
   logic [XLEN-1:0] mem_pc    [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;

   logic            push, pop, bypass, slot_free, fifo_empty, load, fifo_push;
   logic [31:0]     head_instr;
   logic [XLEN-1:0] head_pc;
   decoded_t        head_dec, slot;

   assign in_ready   = (count < CW'(DEPTH));
   assign push       = in_valid && in_ready;
   assign fifo_empty = (count == '0);
   assign slot_free  = !out_valid || out_ready;
   assign pop        = !fifo_empty && slot_free;

`ifdef DECODE_BYPASS_EN
   assign bypass = fifo_empty && push && slot_free;
`else
   assign bypass = 1'b0;
`endif

   assign load       = pop || bypass;
   assign fifo_push  = push && !bypass;
   assign head_instr = bypass ? in_instr : mem_instr[rd_ptr];
   assign head_pc    = bypass ? in_pc    : mem_pc[rd_ptr];

   rv32_decode_comb u_decode (
      .instr (head_instr),
      .dec   (head_dec)
   );

   // storage array carries no reset; validity is tracked entirely by count
   always_ff @(posedge clock) begin
      if (fifo_push && !flush) begin
         mem_instr[wr_ptr] <= in_instr;
         mem_pc[wr_ptr]    <= in_pc;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         slot      <= '0;
         out_pc    <= '0;
         out_instr <= '0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         out_valid <= 1'b0;
      end else begin
         if (fifo_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({fifo_push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (load) begin
            out_valid <= 1'b1;
            slot      <= head_dec;
            out_pc    <= head_pc;
            out_instr <= head_instr;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign out_op_type  = slot.op_type;
   assign out_op_sub   = slot.op_sub;
   assign out_op_flag  = slot.op_flag;
   assign out_imm      = XLEN'($signed(slot.imm));
   assign out_rs1      = slot.rs1;
   assign out_rs2      = slot.rs2;
   assign out_rd       = slot.rd;
   assign out_rs1_used = slot.rs1_used;
   assign out_rs2_used = slot.rs2_used;
   assign out_rd_used  = slot.rd_used;
   assign out_illegal  = slot.illegal;

endmodule
